alu_seq: RTL

- Parametrised, sequential successor to the team's 8-bit combinational ALU.
- Same 4-bit operator encoding and flag semantics, generalised to WIDTH-bit operands.
- Valid/ready handshakes on input and output; registered results.
- Iterative multi-cycle multiply/divide/modulo instead of combinational `*`, `/` and `%`.
- Sits between an operand-issue stage and a result consumer that may apply backpressure.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand-issue side (in_*) and result side (out_*).
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [3:0]           operator;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
  logic                 overflow;
  logic                 carry;

  // Issue stage / result consumer side
  modport master (
    output in_valid, A, B, operator, out_ready,
    input  in_ready, out_valid, out, overflow, carry
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, operator, out_ready,
    output in_ready, out_valid, out, overflow, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU. Single-cycle ops resolve at accept; MUL/DIV/MOD
// iterate one bit per cycle for WIDTH cycles. Result is held in DONE until
// the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b0111;
  localparam logic [3:0] OP_LAND = 4'b1000;
  localparam logic [3:0] OP_LOR  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOT  = 4'b1101;
  localparam logic [3:0] OP_CAT  = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;       // divisor kept for the whole division
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;   // product accumulator
  logic [W2-1:0]    mcand_q, mcand_d; // multiplicand, shifted left each step
  logic [WIDTH-1:0] mq_q, mq_d;     // MUL: multiplier (shifts right); DIV: dividend->quotient
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [W2-1:0]    out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             cy_q, cy_d;

  // ---------------------------------------------------------------------------
  // Single-cycle result, evaluated from the live operands at accept
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   sum, diff;
  logic [W2-1:0]    sc_res;
  logic             sc_ovf, sc_cy;
  logic             iter_op, start_iter;

  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};

  assign iter_op    = (bus.operator == OP_MUL) || (bus.operator == OP_DIV) ||
                      (bus.operator == OP_MOD);
  // A zero B short-circuits: MUL trivially yields 0, DIV/MOD flag overflow.
  assign start_iter = iter_op && (bus.B != '0);

  // Decode the operator into a result and flags for the non-iterative path
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_cy  = 1'b0;
    case (bus.operator)
      OP_ADD: begin
        sc_res = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        sc_cy  = sum[WIDTH];
        sc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        sc_cy  = diff[WIDTH];  // borrow: A < B unsigned
        sc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_DIV, OP_MOD: sc_ovf = (bus.B == '0);
      OP_AND:  sc_res = {{WIDTH{1'b0}}, bus.A & bus.B};
      OP_OR:   sc_res = {{WIDTH{1'b0}}, bus.A | bus.B};
      OP_XOR:  sc_res = {{WIDTH{1'b0}}, bus.A ^ bus.B};
      OP_NOT:  sc_res = {{WIDTH{1'b0}}, ~bus.A};
      OP_EQ:   sc_res[0] = (bus.A == bus.B);
      OP_LAND: sc_res[0] = (bus.A != '0) && (bus.B != '0);
      OP_LOR:  sc_res[0] = (bus.A != '0) || (bus.B != '0);
      OP_SHR: begin
        if (32'(bus.B) < 32'(WIDTH))
          sc_res = {{WIDTH{1'b0}}, bus.A >> bus.B};
      end
      OP_SHL: begin
        if (32'(bus.B) < 32'(W2))
          sc_res = {{WIDTH{1'b0}}, bus.A} << bus.B;
      end
      OP_CAT:  sc_res = {bus.A, bus.B};
      default: sc_res = '0;  // MUL by zero and the reserved code
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration step of shift-add multiply and restoring divide
  // ---------------------------------------------------------------------------
  logic [W2-1:0]    acc_nx, mcand_nx;
  logic [WIDTH:0]   rem_sh, rem_dif;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx, q_nx;

  assign acc_nx   = mq_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mcand_nx = mcand_q << 1;

  // Partial remainder stays below B, so the shifted value is below 2B and
  // the top bit of the trial difference is a clean "didn't fit" indicator.
  assign rem_sh  = {rem_q, mq_q[WIDTH-1]};
  assign rem_dif = rem_sh - {1'b0, b_q};
  assign rem_ge  = ~rem_dif[WIDTH];
  assign rem_nx  = rem_ge ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_nx    = {mq_q[WIDTH-2:0], rem_ge};

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    rem_d   = rem_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.operator;
          b_d   = bus.B;
          cnt_d = '0;
          if (start_iter) begin
            state_d = BUSY;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, bus.A};
            mq_d    = (bus.operator == OP_MUL) ? bus.B : bus.A;
            rem_d   = '0;
          end else begin
            state_d = DONE;
            out_d   = sc_res;
            ovf_d   = sc_ovf;
            cy_d    = sc_cy;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d   = acc_nx;
          mcand_d = mcand_nx;
          mq_d    = mq_q >> 1;
        end else begin
          rem_d = rem_nx;
          mq_d  = q_nx;
        end
        // Final step writes the result directly so DONE follows immediately.
        if (cnt_q == LAST_IT) begin
          state_d = DONE;
          ovf_d   = 1'b0;
          cy_d    = 1'b0;
          case (op_q)
            OP_MUL:  out_d = acc_nx;
            OP_DIV:  out_d = {{WIDTH{1'b0}}, q_nx};
            default: out_d = {{WIDTH{1'b0}}, rem_nx};
          endcase
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      cy_q    <= cy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry     = cy_q;

endmodule
